// File: rtl/demux4_route_sched_pkg.sv
// Shared types and constants for the 1-to-4 demux route scheduler.
// Latency: none (declarations only).
// Backpressure: not applicable.
package demux4_pkg;

   localparam int NUM_CH = 4;

   // Routing mode encodings for the mode input
   localparam logic MODE_ADDR = 1'b0;
   localparam logic MODE_RR   = 1'b1;

   // IDLE: no word held; ROUTE: word held and offered on out_valid[select]
   typedef enum logic {
      IDLE  = 1'b0,
      ROUTE = 1'b1
   } state_t;

endpackage

// File: rtl/demux4_route_sched_rr_pick4.sv
// Rotate-priority finder: first set bit of mask searching ptr, ptr+1, ... (mod 4).
// Latency: purely combinational.
// Backpressure: not applicable; any=0 when mask is empty.
module rr_pick4 (
   input  logic [3:0] mask,
   input  logic [1:0] ptr,
   output logic [1:0] idx,
   output logic       any
);

   logic [1:0] cand;

   // Walk offsets from farthest to nearest so the nearest enabled channel wins
   always_comb begin
      idx  = 2'd0;
      any  = 1'b0;
      cand = ptr;
      for (int i = 3; i >= 0; i--) begin
         cand = ptr + 2'(i);
         if (mask[cand]) begin
            idx = cand;
            any = 1'b1;
         end
      end
   end

endmodule

// File: rtl/demux4_route_sched.sv
// Routes one producer word to one of four consumers (addressed or round-robin), counts deliveries.
// Latency: word accepted at edge N is on out_data/out_valid after edge N; one word per cycle sustained.
// Backpressure: in_ready drops while the held word's channel is not ready, or in RR mode with no channel enabled.
module demux4_route_sched
   import demux4_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int CNT_W  = 8
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              mode,
   input  logic [3:0]        chan_en,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [1:0]        in_dest,
   output logic [1:0]        select,
   output logic [DATA_W-1:0] out_data,
   output logic [3:0]        out_valid,
   input  logic [3:0]        out_ready,
   output logic              drop,
   output logic [CNT_W-1:0]  cnt0,
   output logic [CNT_W-1:0]  cnt1,
   output logic [CNT_W-1:0]  cnt2,
   output logic [CNT_W-1:0]  cnt3
);

   state_t            state, state_nxt;
   logic [1:0]        rr_ptr;
   logic [1:0]        pick_idx;
   logic              pick_any;
   logic [CNT_W-1:0]  cnt [NUM_CH];

   logic              deliver;
   logic              route_ok;
   logic              accept;
   logic              accept_route;
   logic              accept_drop;
   logic [1:0]        next_sel;

   rr_pick4 u_pick (
      .mask (chan_en),
      .ptr  (rr_ptr),
      .idx  (pick_idx),
      .any  (pick_any)
   );

   // Handshake decode: a pending word leaves when its own channel is ready
   always_comb begin
      deliver      = (state == ROUTE) && out_ready[select];
      route_ok     = (mode == MODE_RR) ? pick_any : 1'b1;
      in_ready     = ((state == IDLE) || deliver) && route_ok;
      accept       = in_valid && in_ready;
      accept_route = accept && ((mode == MODE_RR) || chan_en[in_dest]);
      accept_drop  = accept && (mode == MODE_ADDR) && !chan_en[in_dest];
      next_sel     = (mode == MODE_RR) ? pick_idx : in_dest;
   end

   // Next state: a routable accept always (re)enters ROUTE, otherwise a delivery empties us
   always_comb begin
      state_nxt = state;
      if (accept_route) begin
         state_nxt = ROUTE;
      end else if (deliver) begin
         state_nxt = IDLE;
      end
   end

   // State register; reset discards any held word
   always_ff @(posedge clock) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Held word, select, round-robin pointer and drop pulse
   always_ff @(posedge clock) begin
      if (reset) begin
         select   <= 2'd0;
         out_data <= '0;
         rr_ptr   <= 2'd0;
         drop     <= 1'b0;
      end else begin
         drop <= accept_drop;
         if (accept_route) begin
            select   <= next_sel;
            out_data <= in_data;
         end
         if (accept && (mode == MODE_RR)) begin
            rr_ptr <= pick_idx + 2'd1;
         end
      end
   end

   // Per-channel delivery counters, wrapping naturally
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < NUM_CH; i++) begin
            cnt[i] <= '0;
         end
      end else if (deliver) begin
         cnt[select] <= cnt[select] + CNT_W'(1);
      end
   end

   assign out_valid = (state == ROUTE) ? (4'b0001 << select) : 4'b0000;
   assign cnt0 = cnt[0];
   assign cnt1 = cnt[1];
   assign cnt2 = cnt[2];
   assign cnt3 = cnt[3];

endmodule

// File: tb/tb_demux4_route_sched.sv
// Directed bench for demux4_route_sched: reset, addressed, round-robin, backpressure, drop, stall.
// Latency: inputs driven and outputs sampled 1 time unit after each rising edge.
// Backpressure: exercised via out_ready and chan_en patterns.
module tb_demux4_route_sched;

   logic       clock = 1'b0;
   logic       reset;
   logic       mode;
   logic [3:0] chan_en;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_data;
   logic [1:0] in_dest;
   logic [1:0] select;
   logic [7:0] out_data;
   logic [3:0] out_valid;
   logic [3:0] out_ready;
   logic       drop;
   logic [7:0] cnt0, cnt1, cnt2, cnt3;

   int checks = 0;
   int errors = 0;

   always #5 clock = ~clock;

   demux4_route_sched #(.DATA_W(8), .CNT_W(8)) dut (
      .clock     (clock),
      .reset     (reset),
      .mode      (mode),
      .chan_en   (chan_en),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_dest   (in_dest),
      .select    (select),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .drop      (drop),
      .cnt0      (cnt0),
      .cnt1      (cnt1),
      .cnt2      (cnt2),
      .cnt3      (cnt3)
   );

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; mode = 1'b0; chan_en = 4'hF; in_valid = 1'b0;
      in_data = 8'h00; in_dest = 2'd0; out_ready = 4'h0;
      step(); step();
      reset = 1'b0;
      #1;
      checks++; if (out_valid !== 4'b0000) begin errors++; $display("FAIL reset_out_valid got=%b exp=0000", out_valid); end
      checks++; if (select !== 2'd0) begin errors++; $display("FAIL reset_select got=%0d exp=0", select); end
      checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data got=%h exp=00", out_data); end
      checks++; if (drop !== 1'b0) begin errors++; $display("FAIL reset_drop got=%b exp=0", drop); end
      checks++; if ({cnt0, cnt1, cnt2, cnt3} !== 32'h0) begin errors++; $display("FAIL reset_cnts got=%h exp=0", {cnt0, cnt1, cnt2, cnt3}); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
   endtask

   task automatic test_reset_mid_route();
      step();
      mode = 1'b0; chan_en = 4'hF; out_ready = 4'h0;
      in_valid = 1'b1; in_data = 8'hA5; in_dest = 2'd2;
      step();
      in_valid = 1'b0;
      checks++; if (out_valid !== 4'b0100 || out_data !== 8'hA5) begin errors++; $display("FAIL midroute_held got=%b/%h exp=0100/a5", out_valid, out_data); end
      reset = 1'b1;
      step();
      reset = 1'b0;
      #1;
      checks++; if (out_valid !== 4'b0000) begin errors++; $display("FAIL midroute_out_valid got=%b exp=0000", out_valid); end
      checks++; if (cnt2 !== 8'd0) begin errors++; $display("FAIL midroute_cnt2 got=%0d exp=0", cnt2); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL midroute_in_ready got=%b exp=1", in_ready); end
   endtask

   task automatic test_addressed();
      step();
      mode = 1'b0; chan_en = 4'hF; out_ready = 4'hF;
      in_valid = 1'b1; in_data = 8'h11; in_dest = 2'd3;
      step();
      in_valid = 1'b0;
      checks++; if (select !== 2'd3) begin errors++; $display("FAIL addr_select got=%0d exp=3", select); end
      checks++; if (out_valid !== 4'b1000) begin errors++; $display("FAIL addr_out_valid got=%b exp=1000", out_valid); end
      checks++; if (out_data !== 8'h11) begin errors++; $display("FAIL addr_out_data got=%h exp=11", out_data); end
      step();
      checks++; if (cnt3 !== 8'd1) begin errors++; $display("FAIL addr_cnt3 got=%0d exp=1", cnt3); end
      checks++; if (out_valid !== 4'b0000) begin errors++; $display("FAIL addr_idle got=%b exp=0000", out_valid); end
   endtask

   task automatic test_back_to_back();
      logic [1:0] exp_ch [6];
      exp_ch[0] = 2'd0; exp_ch[1] = 2'd1; exp_ch[2] = 2'd3;
      exp_ch[3] = 2'd0; exp_ch[4] = 2'd1; exp_ch[5] = 2'd3;
      mode = 1'b1; chan_en = 4'b1011; out_ready = 4'hF;
      for (int k = 0; k < 6; k++) begin
         in_valid = 1'b1; in_data = 8'h20 + 8'(k); in_dest = 2'd2;
         #1;
         checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rr_in_ready[%0d] got=%b exp=1", k, in_ready); end
         step();
         checks++; if (select !== exp_ch[k] || out_valid !== (4'b0001 << exp_ch[k]) || out_data !== 8'h20 + 8'(k))
            begin errors++; $display("FAIL rr_word[%0d] got sel=%0d v=%b d=%h exp sel=%0d d=%h", k, select, out_valid, out_data, exp_ch[k], 8'h20 + 8'(k)); end
      end
      in_valid = 1'b0;
      step();
      checks++; if (cnt0 !== 8'd2 || cnt1 !== 8'd2 || cnt2 !== 8'd0 || cnt3 !== 8'd3)
         begin errors++; $display("FAIL rr_cnts got=%0d,%0d,%0d,%0d exp=2,2,0,3", cnt0, cnt1, cnt2, cnt3); end
      checks++; if (out_valid !== 4'b0000) begin errors++; $display("FAIL rr_idle got=%b exp=0000", out_valid); end
   endtask

   task automatic test_backpressure();
      mode = 1'b0; chan_en = 4'hF; out_ready = 4'b1101;
      in_valid = 1'b1; in_data = 8'h5A; in_dest = 2'd1;
      step();
      in_data = 8'h66; in_dest = 2'd0;
      for (int k = 0; k < 5; k++) begin
         checks++; if (out_valid !== 4'b0010 || out_data !== 8'h5A || select !== 2'd1 || in_ready !== 1'b0)
            begin errors++; $display("FAIL bp_hold[%0d] got v=%b d=%h sel=%0d rdy=%b exp v=0010 d=5a sel=1 rdy=0", k, out_valid, out_data, select, in_ready); end
         step();
      end
      out_ready = 4'hF;
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_rdy got=%b exp=1", in_ready); end
      step();
      in_valid = 1'b0;
      checks++; if (cnt1 !== 8'd3) begin errors++; $display("FAIL bp_cnt1 got=%0d exp=3", cnt1); end
      checks++; if (select !== 2'd0 || out_valid !== 4'b0001 || out_data !== 8'h66)
         begin errors++; $display("FAIL bp_next got sel=%0d v=%b d=%h exp sel=0 v=0001 d=66", select, out_valid, out_data); end
      step();
      checks++; if (cnt0 !== 8'd3) begin errors++; $display("FAIL bp_cnt0 got=%0d exp=3", cnt0); end
   endtask

   task automatic test_drop();
      mode = 1'b0; chan_en = 4'b1011; out_ready = 4'hF;
      in_valid = 1'b1; in_data = 8'h77; in_dest = 2'd2;
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL drop_in_ready got=%b exp=1", in_ready); end
      step();
      in_valid = 1'b0;
      checks++; if (drop !== 1'b1 || out_valid !== 4'b0000) begin errors++; $display("FAIL drop_pulse got d=%b v=%b exp d=1 v=0000", drop, out_valid); end
      step();
      checks++; if (drop !== 1'b0 || out_valid !== 4'b0000) begin errors++; $display("FAIL drop_end got d=%b v=%b exp d=0 v=0000", drop, out_valid); end
      checks++; if (cnt0 !== 8'd3 || cnt1 !== 8'd3 || cnt2 !== 8'd0 || cnt3 !== 8'd3)
         begin errors++; $display("FAIL drop_cnts got=%0d,%0d,%0d,%0d exp=3,3,0,3", cnt0, cnt1, cnt2, cnt3); end
   endtask

   task automatic test_rr_stall();
      mode = 1'b1; chan_en = 4'b0000; out_ready = 4'hF;
      in_valid = 1'b1; in_data = 8'h99; in_dest = 2'd0;
      for (int k = 0; k < 4; k++) begin
         #1;
         checks++; if (in_ready !== 1'b0 || out_valid !== 4'b0000 || drop !== 1'b0)
            begin errors++; $display("FAIL stall[%0d] got rdy=%b v=%b d=%b exp 0/0000/0", k, in_ready, out_valid, drop); end
         step();
      end
      chan_en = 4'b0100;
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stall_release_rdy got=%b exp=1", in_ready); end
      step();
      in_valid = 1'b0;
      checks++; if (select !== 2'd2 || out_valid !== 4'b0100 || out_data !== 8'h99)
         begin errors++; $display("FAIL stall_route got sel=%0d v=%b d=%h exp sel=2 v=0100 d=99", select, out_valid, out_data); end
      step();
      checks++; if (cnt2 !== 8'd1) begin errors++; $display("FAIL stall_cnt2 got=%0d exp=1", cnt2); end
   endtask

   initial begin
      test_reset();
      test_reset_mid_route();
      test_addressed();
      test_back_to_back();
      test_backpressure();
      test_drop();
      test_rr_stall();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
